// File: rtl/fu_complete_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fu_complete_arbiter_if
// Purpose  : Bundle of FU-result and complete-port signals between the
//            functional units (master side) and the completion arbiter
//            (slave side).
// Revision : 1.0 - initial release
// ============================================================================
interface fu_complete_arbiter_if #(
    parameter int NUM_FU    = 6,
    parameter int CDB_WIDTH = 1,
    parameter int PKT_W     = 64
);
    localparam int SRC_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]                 fu_valid_in;
    logic [NUM_FU-1:0][PKT_W-1:0]      fu_pkt_in;
    logic [NUM_FU-1:0]                 fu_ready_out;
    logic [CDB_WIDTH-1:0]              cdb_valid_out;
    logic [CDB_WIDTH-1:0][PKT_W-1:0]   cdb_pkt_out;
    logic [CDB_WIDTH-1:0][SRC_W-1:0]   cdb_src_out;
    logic                              stall_fu_2_dispatch;

    // Producer / consumer side (functional units plus complete stage)
    modport master (
        output fu_valid_in, fu_pkt_in,
        input  fu_ready_out, cdb_valid_out, cdb_pkt_out, cdb_src_out,
        input  stall_fu_2_dispatch
    );

    // Arbiter side
    modport slave (
        input  fu_valid_in, fu_pkt_in,
        output fu_ready_out, cdb_valid_out, cdb_pkt_out, cdb_src_out,
        output stall_fu_2_dispatch
    );
endinterface
`default_nettype wire

// File: rtl/fu_complete_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fu_complete_arbiter
// Purpose  : Per-FU result FIFOs feeding up to CDB_WIDTH complete ports per
//            cycle. Default arbitration is fixed priority (highest channel
//            index wins); define FU_CMPL_RR_ARB_EN for round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module fu_complete_arbiter #(
    parameter int NUM_FU    = 6,
    parameter int BUF_DEPTH = 2,
    parameter int CDB_WIDTH = 1,
    parameter int PKT_W     = 64
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             flush,
    fu_complete_arbiter_if.slave  bus
);
    localparam int SRC_W = $clog2(NUM_FU);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    // Payload storage carries no valid state, so it is never reset
    logic [PKT_W-1:0]              mem_q [NUM_FU][BUF_DEPTH];
    logic [NUM_FU-1:0][PTR_W-1:0]  head_q, head_d;
    logic [NUM_FU-1:0][PTR_W-1:0]  tail_q, tail_d;
    logic [NUM_FU-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_FU-1:0]             ready_w;
    logic [NUM_FU-1:0]             push_w;
    logic [NUM_FU-1:0]             pop_w;
    logic [CDB_WIDTH-1:0]          cdb_valid_w;
    logic [CDB_WIDTH-1:0][PKT_W-1:0] cdb_pkt_w;
    logic [CDB_WIDTH-1:0][SRC_W-1:0] cdb_src_w;
    int                            ch_w;
    int                            port_w;

`ifdef FU_CMPL_RR_ARB_EN
    logic [SRC_W-1:0]              rr_q, rr_d;
`endif

    // Ready depends on registered count only: a pop this cycle does not open a full channel
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            ready_w[i] = (cnt_q[i] != FULL_CNT);
        end
    end

    assign push_w = bus.fu_valid_in & ready_w & {NUM_FU{~flush}};

    // Walk channels in search order and hand non-empty heads to free ports
    always_comb begin
        pop_w       = '0;
        cdb_valid_w = '0;
        cdb_pkt_w   = '0;
        cdb_src_w   = '0;
        port_w      = 0;
        ch_w        = 0;
`ifdef FU_CMPL_RR_ARB_EN
        rr_d        = rr_q;
`endif
        for (int j = 0; j < NUM_FU; j++) begin
`ifdef FU_CMPL_RR_ARB_EN
            ch_w = (int'(rr_q) + j) % NUM_FU;
`else
            ch_w = NUM_FU - 1 - j;
`endif
            if ((cnt_q[ch_w] != '0) && (port_w < CDB_WIDTH)) begin
                pop_w[ch_w]         = 1'b1;
                cdb_valid_w[port_w] = 1'b1;
                cdb_pkt_w[port_w]   = mem_q[ch_w][head_q[ch_w]];
                cdb_src_w[port_w]   = SRC_W'(ch_w);
                port_w              = port_w + 1;
`ifdef FU_CMPL_RR_ARB_EN
                // Ends up as one past the last channel granted this cycle
                rr_d = SRC_W'((ch_w + 1) % NUM_FU);
`endif
            end
        end
    end

    // Pointer/count next state; flush squashes everything and drops this cycle's inputs
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (flush) begin
                head_d[i] = '0;
                tail_d[i] = '0;
                cnt_d[i]  = '0;
            end else begin
                if (push_w[i]) begin
                    tail_d[i] = (tail_q[i] == LAST_PTR) ? '0 : tail_q[i] + 1'b1;
                end
                if (pop_w[i]) begin
                    head_d[i] = (head_q[i] == LAST_PTR) ? '0 : head_q[i] + 1'b1;
                end
                cnt_d[i] = cnt_q[i] + CNT_W'(push_w[i]) - CNT_W'(pop_w[i]);
            end
        end
    end

    // FIFO valid state; asynchronous reset discards every buffered result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload write at the tail slot of each accepting channel
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push_w[i]) begin
                mem_q[i][tail_q[i]] <= bus.fu_pkt_in[i];
            end
        end
    end

`ifdef FU_CMPL_RR_ARB_EN
    // Round-robin start pointer; moves only when something is granted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else if (flush) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign bus.fu_ready_out        = ready_w;
    assign bus.stall_fu_2_dispatch = ~&ready_w;
    assign bus.cdb_valid_out       = cdb_valid_w;
    assign bus.cdb_pkt_out         = cdb_pkt_w;
    assign bus.cdb_src_out         = cdb_src_w;

endmodule
`default_nettype wire

// File: tb/tb_fu_complete_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_complete_arbiter
// Purpose  : Self-checking bench for fu_complete_arbiter: directed scenarios
//            followed by random traffic, compared against a queue model.
//            Honours FU_CMPL_RR_ARB_EN for the expected arbitration order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fu_complete_arbiter;
    localparam int NUM_FU    = 6;
    localparam int BUF_DEPTH = 2;
    localparam int CDB_WIDTH = 1;
    localparam int PKT_W     = 64;
    localparam int SRC_W     = $clog2(NUM_FU);

    typedef logic [NUM_FU-1:0][PKT_W-1:0] pkt_vec_t;

    logic clock;
    logic reset;
    logic flush;

    fu_complete_arbiter_if #(.NUM_FU(NUM_FU), .CDB_WIDTH(CDB_WIDTH), .PKT_W(PKT_W)) bus ();

    fu_complete_arbiter #(
        .NUM_FU(NUM_FU), .BUF_DEPTH(BUF_DEPTH), .CDB_WIDTH(CDB_WIDTH), .PKT_W(PKT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each channel is a shift queue, entry 0 is the oldest
    logic [PKT_W-1:0] mdat [NUM_FU][BUF_DEPTH];
    int               mcnt [NUM_FU];
    int               mrr;
    int               mlast;
    logic [NUM_FU-1:0] mgrant;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_FU-1:0] model_ready();
        logic [NUM_FU-1:0] r;
        for (int c = 0; c < NUM_FU; c++) r[c] = (mcnt[c] != BUF_DEPTH);
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NUM_FU; c++) mcnt[c] = 0;
        mrr = 0;
    endtask

    // Predict this cycle's outputs from the model and compare
    task automatic check_model(string tag);
        int np;
        int c;
        logic [CDB_WIDTH-1:0]            ev;
        logic [CDB_WIDTH-1:0][PKT_W-1:0] ep;
        logic [CDB_WIDTH-1:0][SRC_W-1:0] es;
        logic [NUM_FU-1:0]               er;
        ev = '0; ep = '0; es = '0; np = 0; mgrant = '0; mlast = 0;
        for (int j = 0; j < NUM_FU; j++) begin
`ifdef FU_CMPL_RR_ARB_EN
            c = (mrr + j) % NUM_FU;
`else
            c = NUM_FU - 1 - j;
`endif
            if (mcnt[c] > 0 && np < CDB_WIDTH) begin
                ev[np] = 1'b1;
                ep[np] = mdat[c][0];
                es[np] = SRC_W'(c);
                mgrant[c] = 1'b1;
                mlast = c;
                np++;
            end
        end
        er = model_ready();
        chk({tag, "_valid"}, 64'(bus.cdb_valid_out), 64'(ev));
        for (int k = 0; k < CDB_WIDTH; k++) begin
            chk($sformatf("%s_pkt%0d", tag, k), 64'(bus.cdb_pkt_out[k]), 64'(ep[k]));
            chk($sformatf("%s_src%0d", tag, k), 64'(bus.cdb_src_out[k]), 64'(es[k]));
        end
        chk({tag, "_ready"}, 64'(bus.fu_ready_out), 64'(er));
        chk({tag, "_stall"}, 64'(bus.stall_fu_2_dispatch), 64'(~&er));
    endtask

    // One clock cycle: check, drive inputs, advance model at the edge
    task automatic step(string tag, logic [NUM_FU-1:0] v, pkt_vec_t p, logic fl);
        logic [NUM_FU-1:0] acc;
        check_model(tag);
        bus.fu_valid_in = v;
        bus.fu_pkt_in   = p;
        flush           = fl;
        acc = v & model_ready();
        @(posedge clock);
        if (fl) begin
            model_clear();
        end else begin
            for (int c = 0; c < NUM_FU; c++) begin
                if (mgrant[c]) begin
                    for (int k = 0; k < BUF_DEPTH - 1; k++) mdat[c][k] = mdat[c][k + 1];
                    mcnt[c]--;
                end
            end
            for (int c = 0; c < NUM_FU; c++) begin
                if (acc[c]) begin
                    mdat[c][mcnt[c]] = p[c];
                    mcnt[c]++;
                end
            end
            if (|mgrant) mrr = (mlast + 1) % NUM_FU;
        end
        #1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_valid"}, 64'(bus.cdb_valid_out), 64'(0));
        chk({tag, "_pkt"},   64'(bus.cdb_pkt_out),   64'(0));
        chk({tag, "_src"},   64'(bus.cdb_src_out),   64'(0));
        chk({tag, "_ready"}, 64'(bus.fu_ready_out),  64'({NUM_FU{1'b1}}));
        chk({tag, "_stall"}, 64'(bus.stall_fu_2_dispatch), 64'(0));
    endtask

    pkt_vec_t          p;
    pkt_vec_t          hp;
    logic [NUM_FU-1:0] hv;
    logic [NUM_FU-1:0] acc;
    logic              fl;
    int                exp_src [3];

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.fu_valid_in = '0;
        bus.fu_pkt_in   = '0;
        model_clear();
        #2;
        chk_reset_outputs("rst");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Single result on channel 3
        p = '0;
        p[3] = 64'hA5;
        step("t1_in", 6'b001000, p, 1'b0);
        chk("t1_valid", 64'(bus.cdb_valid_out[0]), 64'(1));
        chk("t1_pkt",   64'(bus.cdb_pkt_out[0]),   64'hA5);
        chk("t1_src",   64'(bus.cdb_src_out[0]),   64'(3));
        step("t1_out", '0, '0, 1'b0);
        chk("t1_empty", 64'(bus.cdb_valid_out[0]), 64'(0));

        // Arbitration order; flush first so the round-robin start is 0
        step("pf", '0, '0, 1'b1);
        p = '0;
        p[0] = 64'h100; p[2] = 64'h102; p[5] = 64'h105;
`ifdef FU_CMPL_RR_ARB_EN
        exp_src[0] = 0; exp_src[1] = 2; exp_src[2] = 5;
`else
        exp_src[0] = 5; exp_src[1] = 2; exp_src[2] = 0;
`endif
        step("pr_in", 6'b100101, p, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("pr_src%0d", k), 64'(bus.cdb_src_out[0]), 64'(exp_src[k]));
            step("pr", '0, '0, 1'b0);
        end
        chk("pr_done", 64'(bus.cdb_valid_out[0]), 64'(0));

        // Fill channel 1 while channel 5 keeps the port busy
        p = '0;
        p[1] = 64'h1A; p[5] = 64'h5A;
        step("fl_a", 6'b100010, p, 1'b0);
        p[1] = 64'h1B; p[5] = 64'h5B;
        step("fl_b", 6'b100010, p, 1'b0);
`ifndef FU_CMPL_RR_ARB_EN
        chk("fl_full_rdy",   64'(bus.fu_ready_out[1]),     64'(0));
        chk("fl_full_stall", 64'(bus.stall_fu_2_dispatch), 64'(1));
`endif
        p[1] = 64'h1C; p[5] = 64'h5C;
        step("fl_c", 6'b100010, p, 1'b0);
`ifndef FU_CMPL_RR_ARB_EN
        chk("fl_reject_rdy", 64'(bus.fu_ready_out[1]), 64'(0));
`endif
        step("fl_d", 6'b000010, p, 1'b0);
        step("fl_e", 6'b000010, p, 1'b0);
`ifndef FU_CMPL_RR_ARB_EN
        chk("fl_reopen_rdy", 64'(bus.fu_ready_out[1]), 64'(1));
`endif
        step("fl_f", 6'b000010, p, 1'b0);
        repeat (4) step("fl_drain", '0, '0, 1'b0);

        // Flush squashes buffered results and the flush-cycle input
        p = '0;
        p[0] = 64'h200; p[1] = 64'h201; p[4] = 64'h204;
        step("fx_in", 6'b010011, p, 1'b0);
        p = '0;
        p[2] = 64'h202;
        step("fx_flush", 6'b000100, p, 1'b1);
        chk("fx_valid", 64'(bus.cdb_valid_out[0]), 64'(0));
        chk("fx_ready", 64'(bus.fu_ready_out), 64'({NUM_FU{1'b1}}));
        p = '0;
        p[1] = 64'h301; p[4] = 64'h304;
        step("fx_rr", 6'b010010, p, 1'b0);
`ifdef FU_CMPL_RR_ARB_EN
        chk("fx_rr_src", 64'(bus.cdb_src_out[0]), 64'(1));
`else
        chk("fx_rr_src", 64'(bus.cdb_src_out[0]), 64'(4));
`endif
        repeat (3) step("fx_drain", '0, '0, 1'b0);

        // Random traffic; a producer holds its result until it is accepted
        hv = '0;
        hp = '0;
        for (int c = 0; c < 400; c++) begin
            fl = ($urandom_range(0, 39) == 0);
            for (int ch = 0; ch < NUM_FU; ch++) begin
                if (!hv[ch] && ($urandom_range(0, 3) == 0)) begin
                    hv[ch] = 1'b1;
                    hp[ch] = {$urandom, $urandom};
                end
            end
            acc = hv & model_ready();
            step("rnd", hv, hp, fl);
            hv = fl ? '0 : (hv & ~acc);
        end
        bus.fu_valid_in = '0;

        // Asynchronous reset between edges with results buffered
        p = '0;
        p[0] = 64'h400; p[4] = 64'h404;
        step("ar_in", 6'b010001, p, 1'b0);
        step("ar_hold", '0, '0, 1'b0);
        chk("ar_pre_valid", 64'(bus.cdb_valid_out[0]), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("ar");
        #1;
        reset = 1'b0;
        model_clear();
        repeat (3) step("ar_post", '0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fu_complete_arbiter.md
# fu_complete_arbiter

Parametrised completion stage between the functional units and the complete/CDB stage. Each of `NUM_FU` result channels owns a `BUF_DEPTH`-entry FIFO, so finished results wait instead of being lost. Up to `CDB_WIDTH` results are granted per cycle. Per-channel ready and a global dispatch stall provide backpressure, replacing the single-slot buffer and one-hot priority selector of the previous generation.

## Interface
- `NUM_FU`, 6, number of FU result channels (≥2)
- `BUF_DEPTH`, 2, entries per channel FIFO (≥1)
- `CDB_WIDTH`, 1, complete ports per cycle (1..`NUM_FU`)
- `PKT_W`, 64, packed FU_COMPLETE_PACKET width in bits
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `flush` in 1: synchronous squash (branch mispredict)
- `fu_valid_in` in `NUM_FU`: channel i presents a result
- `fu_pkt_in` in `NUM_FU`×`PKT_W`: result payloads
- `fu_ready_out` out `NUM_FU`: channel i FIFO not full
- `cdb_valid_out` out `CDB_WIDTH`: port k carries a result
- `cdb_pkt_out` out `CDB_WIDTH`×`PKT_W`: granted payloads
- `cdb_src_out` out `CDB_WIDTH`×`$clog2(NUM_FU)`: source channel index
- `stall_fu_2_dispatch` out 1: high when any `fu_ready_out` is low

## Operation
- Per channel: circular FIFO with head/tail pointers and a `$clog2(BUF_DEPTH+1)`-bit count. Pointers wrap modulo `BUF_DEPTH`.
- Ready: `fu_ready_out[i] = (count_i != BUF_DEPTH)`. This uses registered count only. Same-cycle dequeue does not open a full channel.
- Enqueue on `fu_valid_in[i] & fu_ready_out[i] & !flush`.
- Valid while not ready: the input is ignored. The producer must hold it; the bench asserts this.
- Candidates are the channels with `count_i > 0`. Only the head is eligible, and each channel gets at most one grant per cycle.
- Grants fill ports 0..`CDB_WIDTH`-1 in search order. Unused ports drive valid=0, pkt=0, src=0.
- Default search order is fixed priority, highest index first: channel `NUM_FU`-1 wins.
- Dequeue: every granted head is popped at the clock edge. A simultaneous enqueue and dequeue on a non-full channel keeps the count unchanged.
- Flush: all counts and pointers go to 0 at the edge, the `flush`-cycle inputs are dropped, and the RR pointer resets to 0. `cdb_*` outputs in the flush cycle are still driven but are not dequeued; the consumer discards them.
- Outputs are combinational from registered FIFO state only, with no input-to-output path.

## Timing
- Latency: a result enqueued at edge N is visible on `cdb_*` in cycle N+1, at the earliest.
- Throughput: `min(CDB_WIDTH, #nonempty)` results per cycle.
- Reset (async): all counts and pointers go to 0 and the RR pointer goes to 0.
  - `fu_ready_out` = all 1s.
  - `cdb_valid_out` = 0, `cdb_pkt_out` = 0, `cdb_src_out` = 0.
  - `stall_fu_2_dispatch` = 0.
- Reset asserted mid-operation discards all buffered results immediately.
- `stall_fu_2_dispatch` asserts in the same cycle the last free entry of any channel is consumed, i.e. on count reaching `BUF_DEPTH`. It drops the cycle after that channel is popped.
- FIFO data storage is not reset; only valid state is reset.

## Configuration
- `FU_CMPL_RR_ARB_EN` defined: round-robin arbitration.
  - The search starts at `rr_ptr` and wraps through increasing indices.
  - After any grant, `rr_ptr <= (last granted index + 1) mod NUM_FU`.
  - With no grant, `rr_ptr` is unchanged.
- Undefined: fixed priority, highest index first. `rr_ptr` logic is not compiled.

## Test plan
- Reset, then values 6/2/1: drive valid on ch3 with pkt 0xA5 for one cycle. The next cycle shows `cdb_valid_out`=1, pkt 0xA5, src 3. The cycle after shows `cdb_valid_out`=0.
- Fixed priority: pulse ch0, ch2 and ch5 in one cycle. Outputs over the next 3 cycles come from src 5, 2, 0.
  - With `FU_CMPL_RR_ARB_EN` and `rr_ptr`=0, the order is 0, 2, 5.
- Full: enqueue 2 results on ch1 while ch5 is kept busy. Then `fu_ready_out[1]`=0 and `stall_fu_2_dispatch`=1.
  - A third valid on ch1 is not accepted.
  - Once the ch1 head is granted, ready returns to 1 the following cycle.
- `CDB_WIDTH`=2: enqueue on ch4 and ch1 together. The next cycle shows port0 src 4 and port1 src 1, both valid. Both FIFOs are empty afterwards.
- Flush: buffer 3 results, then assert `flush` with a new valid on ch2. The next cycle shows `cdb_valid_out`=0, all ready=1 and the RR pointer at 0.
- Async reset pulse between clock edges with FIFOs non-empty: outputs go to reset values immediately, before the next edge.
